div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 203 ++++++++++++++++++++
 tb/tb_div_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, one quotient bit per clock.
// Optional macro: DIV_SEQ_SIGNED_EN builds signed mode (signed_op=1). Without it
// signed_op is ignored and every operation is unsigned.
//
// state | meaning
// IDLE  | after reset, waiting for start
// DIV   | one shift-subtract step per edge, MSB of dividend first
// FIX   | sign correction / divide-by-zero override, results registered
// DONE  | results valid (rdy=1), waiting for the next start
module div_seq #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BITS-1:0] n,
    input  logic [BITS-1:0] d,
    input  logic            signed_op,
    output logic [BITS-1:0] q,
    output logic [BITS-1:0] r,
    output logic            rdy,
    output logic            busy,
    output logic            dbz
);

    localparam int CW = $clog2(BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] rem_q, rem_d;
    logic [BITS-1:0] acc_q, acc_d;
    logic [BITS-1:0] dmag_q, dmag_d;
    logic            dz_q, dz_d;
    logic [BITS-1:0] q_q, q_d;
    logic [BITS-1:0] r_q, r_d;
    logic            rdy_q, rdy_d;
    logic            busy_q, busy_d;
    logic            dbz_q, dbz_d;

    logic [BITS-1:0] n_mag, d_mag;
    logic [BITS:0]   rem_sh, rem_step;
    logic            rem_ge;
    logic [BITS-1:0] q_fix, r_fix;
    logic            unused_rem_msb;

`ifdef DIV_SEQ_SIGNED_EN
    logic n_neg, d_neg;
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    // Operand magnitudes; -MIN wraps to MIN, which is the correct unsigned magnitude.
    always_comb begin
        n_neg = signed_op & n[BITS-1];
        d_neg = signed_op & d[BITS-1];
        n_mag = n_neg ? (~n + 1'b1) : n;
        d_mag = d_neg ? (~d + 1'b1) : d;
    end

    // Sign correction applied in FIX; a zero divisor forces the all-ones quotient.
    always_comb begin
        q_fix = dz_q ? '1 : (qneg_q ? (~acc_q + 1'b1) : acc_q);
        r_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Sign bookkeeping captured alongside the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    // Quotient negative when operand signs differ; remainder follows the dividend.
    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if ((state_q == IDLE || state_q == DONE) && start) begin
            qneg_d = n_neg ^ d_neg;
            rneg_d = n_neg;
        end
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;

    // Unsigned only: operands are already magnitudes.
    always_comb begin
        n_mag = n;
        d_mag = d;
    end

    // A zero divisor leaves rem = n naturally; only the quotient needs forcing.
    always_comb begin
        q_fix = dz_q ? '1 : acc_q;
        r_fix = rem_q;
    end
`endif

    // One restoring step, BITS+1 wide so the compare/subtract never overflows.
    always_comb begin
        rem_sh   = {rem_q, acc_q[BITS-1]};
        rem_ge   = (rem_sh >= {1'b0, dmag_q});
        rem_step = rem_ge ? (rem_sh - {1'b0, dmag_q}) : rem_sh;
    end

    // After a restore the partial remainder is always below the divisor, so the MSB is zero.
    assign unused_rem_msb = rem_step[BITS];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            dmag_q  <= '0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            dmag_q  <= dmag_d;
            dz_q    <= dz_d;
            q_q     <= q_d;
            r_q     <= r_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath control; acc holds the dividend and fills with quotient bits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        dmag_d  = dmag_q;
        dz_d    = dz_q;
        q_d     = q_q;
        r_d     = r_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = n_mag;
                    rem_d   = '0;
                    dmag_d  = d_mag;
                    dz_d    = (d == '0);
                    cnt_d   = CW'(BITS - 1);
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = rem_step[BITS-1:0];
                acc_d = {acc_q[BITS-2:0], rem_ge};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                q_d     = q_fix;
                r_d     = r_fix;
                dbz_d   = dz_q;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign q    = q_q;
    assign r    = r_q;
    assign rdy  = rdy_q;
    assign busy = busy_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: BITS=8 and BITS=32 instances checked every cycle against a
// cycle-level behavioural model built on plain integer division.
module tb_div_seq;

`ifdef DIV_SEQ_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n8, start8, so8, rdy8, busy8, dbz8;
    logic [7:0]  n8, d8, q8, r8;
    logic        rst_n32, start32, so32, rdy32, busy32, dbz32;
    logic [31:0] n32, d32, q32, r32;

    div_seq #(.BITS(8)) u_div8 (
        .clk(clk), .rst_n(rst_n8), .start(start8), .n(n8), .d(d8), .signed_op(so8),
        .q(q8), .r(r8), .rdy(rdy8), .busy(busy8), .dbz(dbz8)
    );

    div_seq #(.BITS(32)) u_div32 (
        .clk(clk), .rst_n(rst_n32), .start(start32), .n(n32), .d(d32), .signed_op(so32),
        .q(q32), .r(r32), .rdy(rdy32), .busy(busy32), .dbz(dbz32)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // model state, index 0 = 8-bit instance, 1 = 32-bit instance
    bit          m_busy[2], m_rdy[2], m_chk[2], m_dbz[2], p_dbz[2];
    int          m_left[2], m_acc[2];
    logic [63:0] m_q[2], m_r[2], p_q[2], p_r[2];

    function automatic int bits_of(input int i);
        return (i == 0) ? 8 : 32;
    endfunction

    function automatic logic [63:0] mask_of(input int bits);
        return (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference division from the arithmetic definition.
    function automatic void ref_div(input int bits, input logic [63:0] n, input logic [63:0] d,
                                    input bit sgn, output logic [63:0] q, output logic [63:0] r,
                                    output bit dz);
        logic [63:0] m, nn, dd;
        longint sn, sd;
        m  = mask_of(bits);
        nn = n & m;
        dd = d & m;
        dz = 1'b0;
        if (dd == 0) begin
            q  = m;
            r  = nn;
            dz = 1'b1;
        end else if (sgn) begin
            sn = longint'(nn << (64 - bits)) >>> (64 - bits);
            sd = longint'(dd << (64 - bits)) >>> (64 - bits);
            q  = 64'(sn / sd) & m;
            r  = 64'(sn % sd) & m;
        end else begin
            q = nn / dd;
            r = nn % dd;
        end
    endfunction

    task automatic model_reset(input int i);
        m_busy[i] = 1'b0;
        m_rdy[i]  = 1'b0;
        m_chk[i]  = 1'b1;
        m_q[i]    = '0;
        m_r[i]    = '0;
        m_dbz[i]  = 1'b0;
        m_left[i] = 0;
    endtask

    task automatic model_step(input int i, input logic rst, input logic st,
                              input logic [63:0] nv, input logic [63:0] dv, input logic sv);
        logic [63:0] tq, tr;
        bit tz;
        if (!rst) begin
            model_reset(i);
        end else if (!m_busy[i]) begin
            if (st) begin
                ref_div(bits_of(i), nv, dv, sv && SIGNED_EN, tq, tr, tz);
                p_q[i] = tq;
                p_r[i] = tr;
                p_dbz[i] = tz;
                m_busy[i] = 1'b1;
                m_rdy[i]  = 1'b0;
                m_chk[i]  = 1'b0;
                m_left[i] = bits_of(i) + 1;
                m_acc[i]++;
            end
        end else begin
            m_left[i]--;
            if (m_left[i] == 0) begin
                m_busy[i] = 1'b0;
                m_rdy[i]  = 1'b1;
                m_chk[i]  = 1'b1;
                m_q[i]    = p_q[i];
                m_r[i]    = p_r[i];
                m_dbz[i]  = p_dbz[i];
            end
        end
    endtask

    task automatic compare(input int i, input logic bz, input logic rd,
                           input logic [63:0] qv, input logic [63:0] rv, input logic zv);
        string p;
        p = (i == 0) ? "b8" : "b32";
        chk({p, " busy"}, 64'(bz), 64'(m_busy[i]));
        chk({p, " rdy"},  64'(rd), 64'(m_rdy[i]));
        if (m_chk[i]) begin
            chk({p, " q"},   qv, m_q[i]);
            chk({p, " r"},   rv, m_r[i]);
            chk({p, " dbz"}, 64'(zv), 64'(m_dbz[i]));
        end
    endtask

    always @(posedge clk) model_step(0, rst_n8, start8, 64'(n8), 64'(d8), so8);
    always @(posedge clk) model_step(1, rst_n32, start32, 64'(n32), 64'(d32), so32);
    always @(negedge rst_n8) model_reset(0);
    always @(negedge rst_n32) model_reset(1);

    always @(negedge clk) begin
        compare(0, busy8, rdy8, 64'(q8), 64'(r8), dbz8);
        compare(1, busy32, rdy32, 64'(q32), 64'(r32), dbz32);
    end

    task automatic drive(input int i, input bit st, input logic [63:0] nv,
                         input logic [63:0] dv, input bit sv);
        if (i == 0) begin
            start8 = st; n8 = nv[7:0]; d8 = dv[7:0]; so8 = sv;
        end else begin
            start32 = st; n32 = nv[31:0]; d32 = dv[31:0]; so32 = sv;
        end
    endtask

    function automatic logic dut_rdy(input int i);
        return (i == 0) ? rdy8 : rdy32;
    endfunction

    // Directed operation with literal expectations and an exact latency check.
    task automatic dir_op(input int i, input logic [63:0] nv, input logic [63:0] dv, input bit sv,
                          input int inject, input logic [63:0] eq, input logic [63:0] er,
                          input bit ez, input string name);
        int lat;
        int bits;
        bits = bits_of(i);
        @(negedge clk);
        drive(i, 1'b1, nv, dv, sv);
        @(posedge clk);
        #1;
        drive(i, 1'b0, ~nv, ~dv, ~sv);
        lat = 0;
        while (!dut_rdy(i) && lat < bits + 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == inject) drive(i, 1'b1, 64'h3, 64'h1, 1'b0);
            else if (lat == inject + 1) drive(i, 1'b0, 64'h3, 64'h1, 1'b0);
        end
        chk({name, " latency"}, 64'(lat), 64'(bits + 1));
        if (i == 0) begin
            chk({name, " q"}, 64'(q8), eq);
            chk({name, " r"}, 64'(r8), er);
            chk({name, " dbz"}, 64'(dbz8), 64'(ez));
        end else begin
            chk({name, " q"}, 64'(q32), eq);
            chk({name, " r"}, 64'(r32), er);
            chk({name, " dbz"}, 64'(dbz32), 64'(ez));
        end
    endtask

    function automatic logic [63:0] rand_val(input int bits);
        logic [63:0] m;
        m = mask_of(bits);
        case ($urandom % 16)
            0: return 64'd0;
            1: return m;
            2: return 64'd1 << (bits - 1);
            3: return 64'd1;
            4: return 64'($urandom % 8);
            5: return m ^ 64'($urandom % 4);
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    // Random regression; start is held high most cycles so many starts land in DONE.
    task automatic rand_run(input int i, input bit mode, input int nops);
        int target, budget, cyc;
        int bits;
        bits   = bits_of(i);
        target = m_acc[i] + nops;
        budget = nops * (bits + 8) + 200;
        cyc    = 0;
        while (m_acc[i] < target && cyc < budget) begin
            @(negedge clk);
            drive(i, ($urandom % 8) != 0, rand_val(bits), rand_val(bits), mode);
            cyc++;
        end
        @(negedge clk);
        drive(i, 1'b0, 64'd0, 64'd0, 1'b0);
        if (m_acc[i] < target) begin
            n_fail++;
            $display("FAIL rand_run b%0d mode %0d: cycle budget expired", bits, mode);
        end
        repeat (bits + 4) @(negedge clk);
    endtask

    task automatic pin_model();
        logic [63:0] tq, tr;
        bit tz;
        ref_div(8, 64'hF9, 64'h2, 1'b1, tq, tr, tz);
        chk("model s -7/2 q", tq, 64'hFD);
        chk("model s -7/2 r", tr, 64'hFF);
        ref_div(8, 64'hF9, 64'h2, 1'b0, tq, tr, tz);
        chk("model u 249/2 q", tq, 64'h7C);
        chk("model u 249/2 r", tr, 64'h01);
        ref_div(8, 64'h80, 64'hFF, 1'b1, tq, tr, tz);
        chk("model ovf q", tq, 64'h80);
        chk("model ovf r", tr, 64'h00);
        ref_div(32, 64'd100, 64'd7, 1'b0, tq, tr, tz);
        chk("model 100/7 q", tq, 64'd14);
        chk("model 100/7 r", tr, 64'd2);
        ref_div(8, 64'h55, 64'h0, 1'b1, tq, tr, tz);
        chk("model dbz q", tq, 64'hFF);
        chk("model dbz r", tr, 64'h55);
        chk("model dbz flag", 64'(tz), 64'd1);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset(0);
        model_reset(1);
        m_acc[0] = 0;
        m_acc[1] = 0;
        rst_n8 = 1'b0;
        rst_n32 = 1'b0;
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(1, 1'b0, 64'd0, 64'd0, 1'b0);
        pin_model();
        @(negedge clk);
        chk("reset q8", 64'(q8), 64'd0);
        chk("reset r8", 64'(r8), 64'd0);
        chk("reset busy8", 64'(busy8), 64'd0);
        chk("reset rdy8", 64'(rdy8), 64'd0);
        @(negedge clk);
        rst_n8 = 1'b1;
        rst_n32 = 1'b1;

        fork
            begin
                dir_op(0, 64'hF9, 64'h2, 1'b1, -5, SIGNED_EN ? 64'hFD : 64'h7C,
                       SIGNED_EN ? 64'hFF : 64'h01, 1'b0, "neg7_div2");
                dir_op(0, 64'h55, 64'h0, 1'b0, -5, 64'hFF, 64'h55, 1'b1, "dbz_u");
                dir_op(0, 64'h55, 64'h0, 1'b1, -5, 64'hFF, 64'h55, 1'b1, "dbz_s");
                dir_op(0, 64'h85, 64'h0, 1'b1, -5, 64'hFF, 64'h85, 1'b1, "dbz_s_neg");
                dir_op(0, 64'h80, 64'hFF, 1'b1, -5, SIGNED_EN ? 64'h80 : 64'h00,
                       SIGNED_EN ? 64'h00 : 64'h80, 1'b0, "ovf");
                dir_op(0, 64'd100, 64'd7, 1'b0, 3, 64'd14, 64'd2, 1'b0, "mid_start");
                // abort mid-division with an asynchronous reset
                @(negedge clk);
                drive(0, 1'b1, 64'd200, 64'd3, 1'b0);
                @(posedge clk);
                #1;
                drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
                repeat (4) @(posedge clk);
                #3;
                rst_n8 = 1'b0;
                #1;
                chk("abort q", 64'(q8), 64'd0);
                chk("abort r", 64'(r8), 64'd0);
                chk("abort busy", 64'(busy8), 64'd0);
                chk("abort rdy", 64'(rdy8), 64'd0);
                chk("abort dbz", 64'(dbz8), 64'd0);
                @(negedge clk);
                @(negedge clk);
                rst_n8 = 1'b1;
                for (int k = 0; k < 12; k++) begin
                    @(posedge clk);
                    #1;
                    chk("abort no rdy", 64'(rdy8), 64'd0);
                end
                dir_op(0, 64'd200, 64'd3, 1'b0, -5, 64'd66, 64'd2, 1'b0, "after_abort");
                rand_run(0, 1'b0, 2000);
                rand_run(0, 1'b1, 2000);
            end
            begin
                dir_op(1, 64'd100, 64'd7, 1'b0, -5, 64'd14, 64'd2, 1'b0, "u32_100_7");
                dir_op(1, 64'hFFFF_FFF9, 64'd2, 1'b1, -5,
                       SIGNED_EN ? 64'hFFFF_FFFD : 64'h7FFF_FFFC,
                       SIGNED_EN ? 64'hFFFF_FFFF : 64'h1, 1'b0, "s32_neg7_div2");
                rand_run(1, 1'b0, 600);
                rand_run(1, 1'b1, 600);
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
